// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared Fibre Channel definitions: transmission words for the primitives
// the TX framer generates on its own, the K-character mask they use, and
// the framer state encoding.
// ---------------------------------------------------------------------------
package fc_pkg;

  // IDLE and R_RDY ordered sets; the K28.5 lives in the top byte.
  localparam logic [31:0] PRIM_IDLE_WORD  = 32'hBC95_B5B5;
  localparam logic [31:0] PRIM_R_RDY_WORD = 32'hBC95_4A4A;
  localparam logic [3:0]  PRIM_DATAK      = 4'b1000;

  // Value returned for unmapped status register addresses.
  localparam logic [31:0] MM_UNMAPPED     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    TXF_FILL = 2'd0,
    TXF_DATA = 2'd1,
    TXF_GAP  = 2'd2,
    TXF_DROP = 2'd3
  } tx_framer_state_t;

endpackage

// File: rtl/fc_credit_counter.sv
// ---------------------------------------------------------------------------
// fc_credit_counter
// Saturating up/down counter in the range 0..MAX.
//   clk, reset    : clock, asynchronous active-high reset
//   i_inc, i_dec  : one step up / down; both together leave the count alone
//   i_force_max   : load MAX (highest priority)
//   i_clear       : load zero
//   o_count       : current count
//   o_ovf         : one-cycle pulse when an increment hits a full counter
// RST_TO_MAX selects whether reset loads MAX or zero.
// ---------------------------------------------------------------------------
module fc_credit_counter
  import fc_pkg::*;
#(
  parameter int unsigned MAX        = 8,
  parameter int unsigned W          = 8,
  parameter bit          RST_TO_MAX = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_force_max,
  input  logic         i_clear,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  localparam logic [W-1:0] C_MAX   = W'(MAX);
  localparam logic [W-1:0] C_RESET = RST_TO_MAX ? W'(MAX) : W'(0);

  logic [W-1:0] r_count;

  assign o_count = r_count;

  // Overflow: an increment that cannot be absorbed because the count is full
  always_comb begin
    o_ovf = i_inc && !i_dec && !i_force_max && !i_clear && (r_count == C_MAX);
  end

  // Saturating count update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= C_RESET;
    end else if (i_force_max) begin
      r_count <= C_MAX;
    end else if (i_clear) begin
      r_count <= W'(0);
    end else if (i_inc && !i_dec) begin
      if (r_count != C_MAX) begin
        r_count <= r_count + W'(1);
      end else begin
        r_count <= r_count;
      end
    end else if (i_dec && !i_inc) begin
      if (r_count != W'(0)) begin
        r_count <= r_count - W'(1);
      end else begin
        r_count <= r_count;
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/fc_tx_framer.sv
// ---------------------------------------------------------------------------
// fc_tx_framer
// Credit-aware transmit framer for one Fibre Channel port. Passes user frames
// to the transceiver when BB credit allows, pads at least MIN_FILL fill words
// after every EOF, substitutes R_RDY for IDLE when R_RDYs are owed, and
// forwards the link-state primitive stream while the link is not active.
//   clk, reset                    : TX clock, async active-high reset
//   link_active                   : link is in the active state
//   prim_data/prim_datak          : primitive stream used while link is down
//   rrdy_req                      : local buffer freed, owe one R_RDY
//   rrdy_rcvd                     : peer returned one credit
//   usertx_*                      : Avalon-ST frame source (ready out)
//   avtx_data/valid/ready         : transceiver word {datak, data}
//   mm_address/read/readdata      : status registers, 1-cycle read latency
//   credit                        : available BB credit
// ---------------------------------------------------------------------------
module fc_tx_framer
  import fc_pkg::*;
#(
  parameter int unsigned BB_CREDIT   = 8,
  parameter int unsigned MIN_FILL    = 6,
  parameter int unsigned RRDY_PEND_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_active,
  input  logic [31:0] prim_data,
  input  logic [3:0]  prim_datak,
  input  logic        rrdy_req,
  input  logic        rrdy_rcvd,
  input  logic [31:0] usertx_data,
  input  logic        usertx_valid,
  input  logic        usertx_startofpacket,
  input  logic        usertx_endofpacket,
  output logic        usertx_ready,
  output logic [35:0] avtx_data,
  output logic        avtx_valid,
  input  logic        avtx_ready,
  input  logic [2:0]  mm_address,
  input  logic        mm_read,
  output logic [31:0] mm_readdata,
  output logic [7:0]  credit
);

  localparam logic [3:0]  C_FILL_LAST = 4'(MIN_FILL - 1);
  localparam logic [35:0] C_IDLE36    = {PRIM_DATAK, PRIM_IDLE_WORD};
  localparam logic [35:0] C_RRDY36    = {PRIM_DATAK, PRIM_R_RDY_WORD};

  tx_framer_state_t r_state;
  logic [3:0]       r_fill_cnt;
  logic [35:0]      r_avtx_data;
  logic [31:0]      r_frames_tx;
  logic [31:0]      r_frames_aborted;
  logic [31:0]      r_rrdy_tx;
  logic [31:0]      r_credit_ovf;
  logic [31:0]      r_stray;
  logic [31:0]      r_mm_readdata;

  logic [7:0]             w_credit;
  logic                   w_credit_ovf;
  logic [RRDY_PEND_W-1:0] w_pend;
  logic                   w_pend_ovf;
  logic                   w_link_down;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_sof_take;
  logic                   w_emit_rrdy;
  logic                   w_ev_frame_tx;
  logic                   w_ev_abort;
  logic                   w_ev_stray;
  logic [35:0]            w_fill_word;
  logic [35:0]            w_prim_word;
  logic [35:0]            w_user_word;

  assign w_link_down  = !link_active;
  assign usertx_ready = w_ready;
  assign avtx_data    = r_avtx_data;
  assign avtx_valid   = 1'b1;
  assign mm_readdata  = r_mm_readdata;
  assign credit       = w_credit;

  // Available BB credit: spent on each SOF, returned by R_RDY from the peer
  fc_credit_counter #(
    .MAX        (BB_CREDIT),
    .W          (8),
    .RST_TO_MAX (1'b1)
  ) u_bb_credit (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (rrdy_rcvd),
    .i_dec       (w_sof_take),
    .i_force_max (w_link_down),
    .i_clear     (1'b0),
    .o_count     (w_credit),
    .o_ovf       (w_credit_ovf)
  );

  // R_RDYs owed to the peer
  fc_credit_counter #(
    .MAX        ((2 ** RRDY_PEND_W) - 1),
    .W          (RRDY_PEND_W),
    .RST_TO_MAX (1'b0)
  ) u_rrdy_pend (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (rrdy_req),
    .i_dec       (w_emit_rrdy),
    .i_force_max (1'b0),
    .i_clear     (w_link_down),
    .o_count     (w_pend),
    .o_ovf       (w_pend_ovf)
  );

  // Handshake, candidate output words and per-cycle event decode
  always_comb begin
    w_ready = 1'b0;
    if (reset || !avtx_ready) begin
      w_ready = 1'b0;
    end else begin
      case (r_state)
        TXF_FILL: w_ready = link_active && (w_credit != 8'd0);
        TXF_DATA: w_ready = 1'b1;
        TXF_GAP:  w_ready = 1'b0;
        TXF_DROP: w_ready = 1'b1;
        default:  w_ready = 1'b0;
      endcase
    end
    w_accept   = usertx_valid && w_ready;
    w_sof_take = w_accept && link_active && (r_state == TXF_FILL) && usertx_startofpacket;
    // An R_RDY goes out in any fill slot that is not displaced by a new SOF.
    w_emit_rrdy = avtx_ready && link_active && (w_pend != '0) &&
                  (((r_state == TXF_FILL) && !w_sof_take) || (r_state == TXF_GAP));
    w_ev_frame_tx = w_accept && link_active && usertx_endofpacket &&
                    (w_sof_take || (r_state == TXF_DATA));
    w_ev_abort = w_accept && usertx_endofpacket &&
                 ((r_state == TXF_DROP) || ((r_state == TXF_DATA) && !link_active));
    w_ev_stray = w_accept && link_active && (r_state == TXF_FILL) && !usertx_startofpacket;
    w_fill_word = (w_pend != '0) ? C_RRDY36 : C_IDLE36;
    w_prim_word = {prim_datak, prim_data};
    w_user_word = {((usertx_startofpacket || usertx_endofpacket) ? PRIM_DATAK : 4'b0000),
                   usertx_data};
  end

  // Framer FSM and registered transceiver word; frozen while avtx_ready is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= TXF_FILL;
      r_fill_cnt  <= 4'd0;
      r_avtx_data <= C_IDLE36;
    end else if (!avtx_ready) begin
      r_state     <= r_state;
      r_fill_cnt  <= r_fill_cnt;
      r_avtx_data <= r_avtx_data;
    end else begin
      case (r_state)
        TXF_FILL: begin
          r_fill_cnt <= 4'd0;
          if (!link_active) begin
            r_avtx_data <= w_prim_word;
            r_state     <= TXF_FILL;
          end else if (w_sof_take) begin
            r_avtx_data <= w_user_word;
            r_state     <= usertx_endofpacket ? TXF_GAP : TXF_DATA;
          end else begin
            r_avtx_data <= w_fill_word;
            r_state     <= TXF_FILL;
          end
        end
        TXF_DATA: begin
          r_fill_cnt <= 4'd0;
          if (!link_active) begin
            // The word accepted on the cycle the link drops already belongs to the abort.
            r_avtx_data <= w_prim_word;
            r_state     <= (w_accept && usertx_endofpacket) ? TXF_FILL : TXF_DROP;
          end else if (w_accept) begin
            r_avtx_data <= w_user_word;
            r_state     <= usertx_endofpacket ? TXF_GAP : TXF_DATA;
          end else begin
            r_avtx_data <= C_IDLE36;
            r_state     <= TXF_DATA;
          end
        end
        TXF_GAP: begin
          if (!link_active) begin
            r_avtx_data <= w_prim_word;
            r_fill_cnt  <= 4'd0;
            r_state     <= TXF_FILL;
          end else begin
            r_avtx_data <= w_fill_word;
            if (r_fill_cnt == C_FILL_LAST) begin
              r_fill_cnt <= 4'd0;
              r_state    <= TXF_FILL;
            end else begin
              r_fill_cnt <= r_fill_cnt + 4'd1;
              r_state    <= TXF_GAP;
            end
          end
        end
        TXF_DROP: begin
          r_fill_cnt  <= 4'd0;
          r_avtx_data <= w_prim_word;
          r_state     <= (w_accept && usertx_endofpacket) ? TXF_FILL : TXF_DROP;
        end
        default: begin
          r_fill_cnt  <= 4'd0;
          r_avtx_data <= C_IDLE36;
          r_state     <= TXF_FILL;
        end
      endcase
    end
  end

  // Statistics; every event term is already qualified by avtx_ready except the
  // overflow pulses, which must be counted even while the output is frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frames_tx      <= 32'd0;
      r_frames_aborted <= 32'd0;
      r_rrdy_tx        <= 32'd0;
      r_credit_ovf     <= 32'd0;
      r_stray          <= 32'd0;
    end else begin
      r_frames_tx      <= r_frames_tx + {31'd0, w_ev_frame_tx};
      r_frames_aborted <= r_frames_aborted + {31'd0, w_ev_abort};
      r_rrdy_tx        <= r_rrdy_tx + {31'd0, w_emit_rrdy};
      r_credit_ovf     <= r_credit_ovf + {31'd0, w_credit_ovf} + {31'd0, w_pend_ovf};
      r_stray          <= r_stray + {31'd0, w_ev_stray};
    end
  end

  // Registered status read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mm_readdata <= 32'd0;
    end else if (mm_read) begin
      case (mm_address)
        3'd0:    r_mm_readdata <= {24'd0, w_credit};
        3'd1:    r_mm_readdata <= r_frames_tx;
        3'd2:    r_mm_readdata <= r_frames_aborted;
        3'd3:    r_mm_readdata <= r_rrdy_tx;
        3'd4:    r_mm_readdata <= r_credit_ovf;
        3'd5:    r_mm_readdata <= r_stray;
        default: r_mm_readdata <= MM_UNMAPPED;
      endcase
    end else begin
      r_mm_readdata <= r_mm_readdata;
    end
  end

endmodule

// File: tb/tb_fc_tx_framer.sv
// Directed bench for fc_tx_framer with BB_CREDIT=2, MIN_FILL=6.
module tb_fc_tx_framer;

  localparam logic [35:0] IDLE36 = {4'b1000, 32'hBC95_B5B5};
  localparam logic [35:0] RRDY36 = {4'b1000, 32'hBC95_4A4A};
  localparam logic [31:0] PRIM_D = 32'h5A5A_C3C3;
  localparam logic [3:0]  PRIM_K = 4'b0110;
  localparam logic [35:0] PRIM36 = {PRIM_K, PRIM_D};

  logic        clk = 1'b0;
  logic        reset;
  logic        link_active;
  logic [31:0] prim_data;
  logic [3:0]  prim_datak;
  logic        rrdy_req;
  logic        rrdy_rcvd;
  logic [31:0] usertx_data;
  logic        usertx_valid;
  logic        usertx_startofpacket;
  logic        usertx_endofpacket;
  logic        usertx_ready;
  logic [35:0] avtx_data;
  logic        avtx_valid;
  logic        avtx_ready;
  logic [2:0]  mm_address;
  logic        mm_read;
  logic [31:0] mm_readdata;
  logic [7:0]  credit;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;

  fc_tx_framer #(
    .BB_CREDIT   (2),
    .MIN_FILL    (6),
    .RRDY_PEND_W (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .link_active          (link_active),
    .prim_data            (prim_data),
    .prim_datak           (prim_datak),
    .rrdy_req             (rrdy_req),
    .rrdy_rcvd            (rrdy_rcvd),
    .usertx_data          (usertx_data),
    .usertx_valid         (usertx_valid),
    .usertx_startofpacket (usertx_startofpacket),
    .usertx_endofpacket   (usertx_endofpacket),
    .usertx_ready         (usertx_ready),
    .avtx_data            (avtx_data),
    .avtx_valid           (avtx_valid),
    .avtx_ready           (avtx_ready),
    .mm_address           (mm_address),
    .mm_read              (mm_read),
    .mm_readdata          (mm_readdata),
    .credit               (credit)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] kw(input logic [31:0] d);
    return {4'b1000, d};
  endfunction

  function automatic logic [35:0] dw(input logic [31:0] d);
    return {4'b0000, d};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one user word for one edge, then check the registered output.
  task automatic put(input logic [31:0] d, input logic s, input logic e,
                     input logic [35:0] exp, input string tag);
    usertx_data          = d;
    usertx_startofpacket = s;
    usertx_endofpacket   = e;
    usertx_valid         = 1'b1;
    tick();
    usertx_valid         = 1'b0;
    usertx_startofpacket = 1'b0;
    usertx_endofpacket   = 1'b0;
    chk(tag, avtx_data, exp);
  endtask

  // Six gap words: the first n_rrdy are R_RDY, the rest IDLE; user not ready.
  task automatic gap_seq(input string tag, input int n_rrdy);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_rdy"}, 36'(usertx_ready), 36'd0);
      tick();
      chk(tag, avtx_data, (i < n_rrdy) ? RRDY36 : IDLE36);
    end
  endtask

  task automatic mm_rd(input logic [2:0] a, output logic [31:0] d);
    mm_address = a;
    mm_read    = 1'b1;
    tick();
    mm_read    = 1'b0;
    d          = mm_readdata;
  endtask

  initial begin
    reset                = 1'b1;
    link_active          = 1'b1;
    prim_data            = PRIM_D;
    prim_datak           = PRIM_K;
    rrdy_req             = 1'b0;
    rrdy_rcvd            = 1'b0;
    usertx_data          = 32'd0;
    usertx_valid         = 1'b0;
    usertx_startofpacket = 1'b0;
    usertx_endofpacket   = 1'b0;
    avtx_ready           = 1'b1;
    mm_address           = 3'd0;
    mm_read              = 1'b0;

    // Reset state
    tick();
    chk("rst_avtx", avtx_data, IDLE36);
    chk("rst_valid", 36'(avtx_valid), 36'd1);
    chk("rst_ready", 36'(usertx_ready), 36'd0);
    chk("rst_credit", 36'(credit), 36'd2);
    chk("rst_mm", {4'd0, mm_readdata}, 36'd0);
    reset = 1'b0;
    #1;
    chk("fill_ready", 36'(usertx_ready), 36'd1);

    // Frame 1 and 2 consume both credits
    put(32'hA000_0001, 1'b1, 1'b0, kw(32'hA000_0001), "f1_w0");
    put(32'hA000_0002, 1'b0, 1'b0, dw(32'hA000_0002), "f1_w1");
    put(32'hA000_0003, 1'b0, 1'b0, dw(32'hA000_0003), "f1_w2");
    put(32'hA000_0004, 1'b0, 1'b1, kw(32'hA000_0004), "f1_w3");
    gap_seq("f1_gap", 0);
    chk("f1_credit", 36'(credit), 36'd1);
    put(32'hB000_0001, 1'b1, 1'b0, kw(32'hB000_0001), "f2_w0");
    put(32'hB000_0002, 1'b0, 1'b0, dw(32'hB000_0002), "f2_w1");
    put(32'hB000_0003, 1'b0, 1'b0, dw(32'hB000_0003), "f2_w2");
    put(32'hB000_0004, 1'b0, 1'b1, kw(32'hB000_0004), "f2_w3");
    gap_seq("f2_gap", 0);
    chk("nocred_ready", 36'(usertx_ready), 36'd0);
    mm_rd(3'd0, rd);
    chk("mm_credit0", {4'd0, rd}, 36'd0);

    // Frame 3 stalls until a credit returns
    usertx_data          = 32'hC000_0001;
    usertx_startofpacket = 1'b1;
    usertx_valid         = 1'b1;
    #1;
    chk("f3_stall_rdy", 36'(usertx_ready), 36'd0);
    tick();
    tick();
    chk("f3_stall_out", avtx_data, IDLE36);
    rrdy_rcvd = 1'b1;
    tick();
    rrdy_rcvd = 1'b0;
    chk("f3_credit1", 36'(credit), 36'd1);
    chk("f3_unstall_rdy", 36'(usertx_ready), 36'd1);
    put(32'hC000_0001, 1'b1, 1'b0, kw(32'hC000_0001), "f3_w0");
    rrdy_req = 1'b1;
    put(32'hC000_0002, 1'b0, 1'b0, dw(32'hC000_0002), "f3_w1");
    put(32'hC000_0003, 1'b0, 1'b0, dw(32'hC000_0003), "f3_w2");
    put(32'hC000_0004, 1'b0, 1'b1, kw(32'hC000_0004), "f3_w3");
    rrdy_req = 1'b0;
    gap_seq("f3_gap", 3);
    mm_rd(3'd3, rd);
    chk("mm_rrdy_tx", {4'd0, rd}, 36'd3);
    mm_rd(3'd1, rd);
    chk("mm_frames_tx3", {4'd0, rd}, 36'd3);

    // Credit saturation at BB_CREDIT
    rrdy_rcvd = 1'b1;
    tick();
    tick();
    tick();
    rrdy_rcvd = 1'b0;
    chk("ovf_credit_sat", 36'(credit), 36'd2);
    mm_rd(3'd4, rd);
    chk("mm_credit_ovf", {4'd0, rd}, 36'd1);

    // One-word frame, then SOF coincident with rrdy_rcvd at credit 1
    put(32'hD000_0001, 1'b1, 1'b1, kw(32'hD000_0001), "one_word");
    gap_seq("d_gap", 0);
    chk("d_credit", 36'(credit), 36'd1);
    rrdy_rcvd = 1'b1;
    put(32'hE000_0001, 1'b1, 1'b0, kw(32'hE000_0001), "e_w0");
    rrdy_rcvd = 1'b0;
    chk("sof_rrdy_credit", 36'(credit), 36'd1);
    put(32'hE000_0002, 1'b0, 1'b0, dw(32'hE000_0002), "e_w1");

    // Transceiver back-pressure for 5 cycles mid-frame
    usertx_data  = 32'hE000_0003;
    usertx_valid = 1'b1;
    avtx_ready   = 1'b0;
    #1;
    chk("freeze_rdy", 36'(usertx_ready), 36'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_hold", avtx_data, dw(32'hE000_0002));
    end
    avtx_ready = 1'b1;
    put(32'hE000_0003, 1'b0, 1'b0, dw(32'hE000_0003), "e_w2");
    put(32'hE000_0004, 1'b0, 1'b1, kw(32'hE000_0004), "e_w3");
    gap_seq("e_gap", 0);
    mm_rd(3'd1, rd);
    chk("mm_frames_tx5", {4'd0, rd}, 36'd5);

    // Link drops on frame word 2
    put(32'hF000_0001, 1'b1, 1'b0, kw(32'hF000_0001), "g_w0");
    link_active = 1'b0;
    put(32'hF000_0002, 1'b0, 1'b0, PRIM36, "drop_prim1");
    put(32'hF000_0003, 1'b0, 1'b0, PRIM36, "drop_prim2");
    put(32'hF000_0004, 1'b0, 1'b1, PRIM36, "drop_prim3");
    chk("drop_credit", 36'(credit), 36'd2);
    chk("linkdown_rdy", 36'(usertx_ready), 36'd0);
    mm_rd(3'd2, rd);
    chk("mm_aborted", {4'd0, rd}, 36'd1);
    chk("linkdown_prim", avtx_data, PRIM36);
    link_active = 1'b1;
    tick();
    chk("linkup_idle", avtx_data, IDLE36);

    // Stray word in FILL and unmapped registers
    put(32'h5555_0001, 1'b0, 1'b0, IDLE36, "stray_out");
    mm_rd(3'd5, rd);
    chk("mm_stray", {4'd0, rd}, 36'd1);
    mm_rd(3'd6, rd);
    chk("mm_addr6", {4'd0, rd}, {4'd0, 32'hFFFF_FFFF});
    mm_rd(3'd7, rd);
    chk("mm_addr7", {4'd0, rd}, {4'd0, 32'hFFFF_FFFF});

    // Asynchronous reset in the middle of a frame
    put(32'h7000_0001, 1'b1, 1'b0, kw(32'h7000_0001), "h_w0");
    put(32'h7000_0002, 1'b0, 1'b0, dw(32'h7000_0002), "h_w1");
    reset = 1'b1;
    #2;
    chk("amid_reset_out", avtx_data, IDLE36);
    chk("amid_reset_credit", 36'(credit), 36'd2);
    reset = 1'b0;
    #1;
    put(32'h7000_0003, 1'b0, 1'b0, IDLE36, "post_reset_fill");
    mm_rd(3'd1, rd);
    chk("post_reset_frames", {4'd0, rd}, 36'd0);
    mm_rd(3'd5, rd);
    chk("post_reset_stray", {4'd0, rd}, 36'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
